// File: rtl/led_breathe_pwm.sv
// led_breathe_pwm: breathing LED driver for the sysClk domain.
// Brightness ramps up, holds at full, ramps down, holds at zero, and repeats.
// The brightness is rendered as PWM on ledPwm. Level, phase and an end-of-cycle pulse are exported.
// Optional build macro LED_BREATHE_GAMMA_EN: the PWM duty is driven from a squared (gamma)
// version of the brightness instead of the linear level. The level output stays linear.
module led_breathe_pwm #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int STEP_HZ    = 512,
    parameter int PWM_BITS   = 8,
    parameter int HOLD_STEPS = 128
) (
    input  logic                sysClk,
    input  logic                rstN,
    input  logic                en,
    output logic                ledPwm,
    output logic [PWM_BITS-1:0] level,
    output logic [1:0]          phase,
    output logic                periodDone
);

    // Clocks per brightness step; integer division, so STEP_HZ should divide CLK_HZ exactly.
    localparam int DIV    = CLK_HZ / STEP_HZ;
    localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE   = PRE_W'(1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
    localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
    localparam logic [PWM_BITS-1:0] LEVEL_ONE = PWM_BITS'(1);
    // The PWM counter stops one short of MAX so the period is MAX clocks and level MAX is always on.
    localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'((1 << PWM_BITS) - 2);

    typedef enum logic [1:0] {
        RISE    = 2'd0,
        HOLD_HI = 2'd1,
        FALL    = 2'd2,
        HOLD_LO = 2'd3
    } phase_t;

    phase_t              state;
    logic [PRE_W-1:0]    prescaler;
    logic [PWM_BITS-1:0] pwmCnt;
    logic [PWM_BITS-1:0] shadow;
    logic [HOLD_W-1:0]   holdCnt;
    logic [PWM_BITS-1:0] dutySrc;
    logic                stepTick;

    assign stepTick = en && (prescaler == PRE_LAST);
    assign phase    = state;

    // Step prescaler: divides sysClk down to the brightness step rate, frozen while disabled.
    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            prescaler <= '0;
        end else if (en) begin
            if (prescaler == PRE_LAST) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PRE_ONE;
            end
        end
    end

    // PWM period counter: 0..MAX-1, frozen while disabled.
    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            pwmCnt <= '0;
        end else if (en) begin
            if (pwmCnt == PWM_LAST) begin
                pwmCnt <= '0;
            end else begin
                pwmCnt <= pwmCnt + LEVEL_ONE;
            end
        end
    end

`ifdef LED_BREATHE_GAMMA_EN
    localparam int SQ_W = 2 * PWM_BITS;
    localparam logic [SQ_W-1:0] SQ_ONE = SQ_W'(1);

    logic [SQ_W-1:0]     levelPlusOne;
    logic [PWM_BITS-1:0] gammaLevel;

    assign levelPlusOne = {{PWM_BITS{1'b0}}, level} + SQ_ONE;

    // Gamma pipeline stage: ((level+1)^2 - 1) >> PWM_BITS at double width; at level MAX the square
    // wraps to zero and the minus one brings it back to all ones, so MAX still maps to MAX.
    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            gammaLevel <= '0;
        end else begin
            gammaLevel <= PWM_BITS'(((levelPlusOne * levelPlusOne) - SQ_ONE) >> PWM_BITS);
        end
    end

    assign dutySrc = gammaLevel;
`else
    assign dutySrc = level;
`endif

    // Duty shadow: only picks up a new value at the start of a PWM period so the pulse never glitches.
    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            shadow <= '0;
        end else if (en && (pwmCnt == '0)) begin
            shadow <= dutySrc;
        end
    end

    // Registered PWM compare; the pin is held low whenever the block is disabled.
    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            ledPwm <= 1'b0;
        end else if (en) begin
            ledPwm <= (pwmCnt < shadow);
        end else begin
            ledPwm <= 1'b0;
        end
    end

    // Breathing FSM: advances one step per stepTick; level saturates at 0 and MAX, never wraps.
    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            state      <= RISE;
            level      <= '0;
            holdCnt    <= '0;
            periodDone <= 1'b0;
        end else begin
            periodDone <= 1'b0;
            if (stepTick) begin
                case (state)
                    RISE: begin
                        if (level == LEVEL_MAX) begin
                            state   <= HOLD_HI;
                            holdCnt <= '0;
                        end else begin
                            level <= level + LEVEL_ONE;
                        end
                    end
                    HOLD_HI: begin
                        if (holdCnt == HOLD_LAST) begin
                            state <= FALL;
                        end else begin
                            holdCnt <= holdCnt + HOLD_ONE;
                        end
                    end
                    FALL: begin
                        if (level == '0) begin
                            state   <= HOLD_LO;
                            holdCnt <= '0;
                        end else begin
                            level <= level - LEVEL_ONE;
                        end
                    end
                    HOLD_LO: begin
                        if (holdCnt == HOLD_LAST) begin
                            state      <= RISE;
                            periodDone <= 1'b1;
                        end else begin
                            holdCnt <= holdCnt + HOLD_ONE;
                        end
                    end
                    default: begin
                        state <= RISE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_breathe_pwm.sv
// tb_led_breathe_pwm: scoreboard bench for led_breathe_pwm with DIV=10, MAX=7, HOLD_STEPS=2.
// Edge numbering: edge 1 is the first rising edge after rstN is released with en=1.
module tb_led_breathe_pwm;

    logic       sysClk = 1'b0;
    logic       rstN;
    logic       en;
    logic       ledPwm;
    logic [2:0] level;
    logic [1:0] phase;
    logic       periodDone;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        int         edgeNum;
        logic [2:0] lvl;
        logic [1:0] ph;
    } stepExp_t;

    typedef struct {
        int lastEdge;
        int highs;
    } windowExp_t;

    stepExp_t   stepQ[$];
    windowExp_t windowQ[$];

    led_breathe_pwm #(
        .CLK_HZ    (1000),
        .STEP_HZ   (100),
        .PWM_BITS  (3),
        .HOLD_STEPS(2)
    ) dut (
        .sysClk    (sysClk),
        .rstN      (rstN),
        .en        (en),
        .ledPwm    (ledPwm),
        .level     (level),
        .phase     (phase),
        .periodDone(periodDone)
    );

    // 10 ns clock period.
    always #5 sysClk = ~sysClk;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected tests to complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Holds reset across one rising edge and releases it with en=1 on a falling edge.
    task automatic doReset();
        @(negedge sysClk);
        rstN = 1'b0;
        en   = 1'b0;
        @(negedge sysClk);
        rstN = 1'b1;
        en   = 1'b1;
    endtask

    // Advances one rising edge and returns on the following falling edge for sampling.
    task automatic tick();
        @(posedge sysClk);
        @(negedge sysClk);
    endtask

    // Reset state must appear before any clock edge has occurred.
    task automatic test_reset();
        rstN = 1'b1;
        en   = 1'b0;
        #1;
        rstN = 1'b0;
        #1;
        assertCount++;
        if (ledPwm !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_ledPwm: got %b expected 0", ledPwm);
        end
        assertCount++;
        if (level !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL reset_level: got %0d expected 0", level);
        end
        assertCount++;
        if (phase !== 2'd0) begin
            failCount++;
            $display("[TB] FAIL reset_phase: got %0d expected 0", phase);
        end
        assertCount++;
        if (periodDone !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_periodDone: got %b expected 0", periodDone);
        end
    endtask

    // Level steps every 10 edges during RISE.
    task automatic test_step_timing();
        stepExp_t item;
        doReset();
        for (int n = 1; n <= 25; n++) begin
            stepQ.push_back('{edgeNum: n, lvl: 3'(n / 10), ph: 2'd0});
        end
        for (int n = 1; n <= 25; n++) begin
            tick();
            if (stepQ.size() > 0 && stepQ[0].edgeNum == n) begin
                item = stepQ.pop_front();
                assertCount++;
                if (level !== item.lvl || phase !== item.ph) begin
                    failCount++;
                    $display("[TB] FAIL step_timing edge %0d: got level %0d phase %0d, expected level %0d phase %0d",
                             n, level, phase, item.lvl, item.ph);
                end
            end
        end
        assertCount++;
        if (stepQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL step_timing_leftover: got %0d pending, expected 0", stepQ.size());
        end
        stepQ.delete();
    endtask

    // Duty over whole PWM periods whose shadow was latched at level 0, 3 and 7.
    task automatic test_duty();
        windowExp_t w;
        int acc;
        acc = 0;
        doReset();
        windowQ.push_back('{lastEdge: 7, highs: 0});
`ifdef LED_BREATHE_GAMMA_EN
        windowQ.push_back('{lastEdge: 42, highs: 1});
`else
        windowQ.push_back('{lastEdge: 42, highs: 3});
`endif
        windowQ.push_back('{lastEdge: 84, highs: 7});
        for (int n = 1; n <= 84; n++) begin
            tick();
            if (windowQ.size() > 0 && n >= windowQ[0].lastEdge - 6) begin
                if (ledPwm === 1'b1) acc++;
                if (n == windowQ[0].lastEdge) begin
                    w = windowQ.pop_front();
                    assertCount++;
                    if (acc != w.highs) begin
                        failCount++;
                        $display("[TB] FAIL duty window ending edge %0d: got %0d/7 high, expected %0d/7",
                                 n, acc, w.highs);
                    end
                    acc = 0;
                end
            end
        end
        assertCount++;
        if (windowQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL duty_leftover: got %0d pending, expected 0", windowQ.size());
        end
        windowQ.delete();
    endtask

    // Two full breathing cycles: phase transitions and periodDone pulses.
    task automatic test_full_cycle();
        stepExp_t   item;
        logic [1:0] prevPhase;
        logic       pdExp;
        doReset();
        for (int c = 0; c < 2; c++) begin
            stepQ.push_back('{edgeNum: 80 + 200 * c,  lvl: 3'd7, ph: 2'd1});
            stepQ.push_back('{edgeNum: 100 + 200 * c, lvl: 3'd7, ph: 2'd2});
            stepQ.push_back('{edgeNum: 180 + 200 * c, lvl: 3'd0, ph: 2'd3});
            stepQ.push_back('{edgeNum: 200 + 200 * c, lvl: 3'd0, ph: 2'd0});
        end
        prevPhase = 2'd0;
        for (int n = 1; n <= 410; n++) begin
            tick();
            pdExp = (n == 200 || n == 400);
            assertCount++;
            if (periodDone !== pdExp) begin
                failCount++;
                $display("[TB] FAIL periodDone edge %0d: got %b expected %b", n, periodDone, pdExp);
            end
            if (phase !== prevPhase) begin
                assertCount++;
                if (stepQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL phase_change edge %0d: got phase %0d, expected no change", n, phase);
                end else begin
                    item = stepQ.pop_front();
                    if (n != item.edgeNum || phase !== item.ph || level !== item.lvl) begin
                        failCount++;
                        $display("[TB] FAIL phase_change: got edge %0d phase %0d level %0d, expected edge %0d phase %0d level %0d",
                                 n, phase, level, item.edgeNum, item.ph, item.lvl);
                    end
                end
                prevPhase = phase;
            end
        end
        assertCount++;
        if (stepQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL phase_sequence_leftover: got %0d pending, expected 0", stepQ.size());
        end
        stepQ.delete();
    endtask

    // Freeze at level 4 with prescaler at 5, then resume: 5 more enabled edges reach level 5.
    task automatic test_freeze();
        stepExp_t item;
        doReset();
        for (int n = 1; n <= 45; n++) tick();
        assertCount++;
        if (level !== 3'd4 || ledPwm !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL freeze_pre: got level %0d ledPwm %b, expected level 4 ledPwm 1", level, ledPwm);
        end
        en = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            tick();
            assertCount++;
            if (level !== 3'd4 || phase !== 2'd0 || ledPwm !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL freeze edge %0d: got level %0d phase %0d ledPwm %b, expected 4 0 0",
                         n, level, phase, ledPwm);
            end
        end
        en = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            stepQ.push_back('{edgeNum: n, lvl: (n == 5) ? 3'd5 : 3'd4, ph: 2'd0});
        end
        for (int n = 1; n <= 5; n++) begin
            tick();
            if (stepQ.size() > 0 && stepQ[0].edgeNum == n) begin
                item = stepQ.pop_front();
                assertCount++;
                if (level !== item.lvl || phase !== item.ph) begin
                    failCount++;
                    $display("[TB] FAIL resume edge %0d: got level %0d phase %0d, expected level %0d phase %0d",
                             n, level, phase, item.lvl, item.ph);
                end
            end
        end
        stepQ.delete();
    endtask

    // Asynchronous reset mid-FALL at level 5, then step timing restarts from zero.
    task automatic test_async_reset();
        stepExp_t item;
        doReset();
        for (int n = 1; n <= 125; n++) tick();
        assertCount++;
        if (level !== 3'd5 || phase !== 2'd2 || ledPwm !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL async_pre: got level %0d phase %0d ledPwm %b, expected 5 2 1", level, phase, ledPwm);
        end
        #2;
        rstN = 1'b0;
        #1;
        assertCount++;
        if (level !== 3'd0 || phase !== 2'd0 || ledPwm !== 1'b0 || periodDone !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL async_reset: got level %0d phase %0d ledPwm %b periodDone %b, expected all 0",
                     level, phase, ledPwm, periodDone);
        end
        @(negedge sysClk);
        rstN = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            stepQ.push_back('{edgeNum: n, lvl: 3'(n / 10), ph: 2'd0});
        end
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (stepQ.size() > 0 && stepQ[0].edgeNum == n) begin
                item = stepQ.pop_front();
                assertCount++;
                if (level !== item.lvl || phase !== item.ph) begin
                    failCount++;
                    $display("[TB] FAIL post_reset edge %0d: got level %0d phase %0d, expected level %0d phase %0d",
                             n, level, phase, item.lvl, item.ph);
                end
            end
        end
        stepQ.delete();
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_step_timing();
        test_duty();
        test_full_cycle();
        test_freeze();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
